fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined RV32 core. It replaces the bare PC register and IF/ID latch with a PC generator, a 1-cycle-latency instruction-memory request port and a DEPTH-entry prefetch FIFO. It feeds decode over a valid/ready handshake, and branch/jump redirects flush the FIFO and drop any in-flight fetch. Decode stalls (load-use) become back-pressure instead of a frozen PC.

---
 rtl/fetch_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, 1-cycle imem port and
// a prefetch FIFO feeding decode over valid/ready.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc4,
  output logic [31:0]                out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [31:0]     r_inst_mem [DEPTH];

  logic [CW:0]     w_used;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_push_pc;
  logic            w_unused_rpc;

  assign w_unused_rpc = ^redirect_pc[1:0];

  // Credit: entries held plus the word still coming back.
  assign w_used = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = !rst && !redirect_valid &&
                  (w_used < (CW+1)'(DEPTH));
  assign w_push = r_inflight && !redirect_valid;
  assign w_pop  = out_valid && out_ready && !redirect_valid;

  // fetch_pc already advanced past the word now returning.
  assign w_push_pc = r_fetch_pc - XLEN'(4);

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr] : '0;
  assign out_pc4   = out_pc + XLEN'(4);
  assign out_inst  = out_valid ? r_inst_mem[r_rd_ptr] : NOP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_req) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
        r_inflight <= 1'b1;
      end else begin
        r_inflight <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_pc_mem[r_wr_ptr]   <= w_push_pc;
      r_inst_mem[r_wr_ptr] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && r_count == CW'(DEPTH)));

endmodule
